// File: rtl/bp_lite_to_burst_pkg.sv
// bp_lite_to_burst_pkg
//   Shared types for the Lite-to-Burst memory message converter: message
//   type and size encodings, the memory header layout, and the beat-count
//   helper that the burst-to-lite side uses as well.
package bp_lite_to_burst_pkg;

   localparam int paddr_width_gp = 40;

   typedef enum logic [3:0] {
      e_bp_mem_msg_rd    = 4'd0,
      e_bp_mem_msg_wr    = 4'd1,
      e_bp_mem_msg_uc_rd = 4'd2,
      e_bp_mem_msg_uc_wr = 4'd3,
      e_bp_mem_msg_pre   = 4'd4
   } bp_mem_msg_e;

   // A size code s describes a 2**s byte transfer.
   typedef enum logic [2:0] {
      e_bp_mem_msg_size_1   = 3'd0,
      e_bp_mem_msg_size_2   = 3'd1,
      e_bp_mem_msg_size_4   = 3'd2,
      e_bp_mem_msg_size_8   = 3'd3,
      e_bp_mem_msg_size_16  = 3'd4,
      e_bp_mem_msg_size_32  = 3'd5,
      e_bp_mem_msg_size_64  = 3'd6,
      e_bp_mem_msg_size_128 = 3'd7
   } bp_mem_msg_size_e;

   typedef struct packed {
      logic [7:0]                payload;
      bp_mem_msg_size_e          size;
      logic [paddr_width_gp-1:0] addr;
      bp_mem_msg_e               msg_type;
   } bp_mem_msg_header_s;

   localparam int mem_header_width_gp = $bits(bp_mem_msg_header_s);

   // Beats needed to carry a 2**size byte transfer over 2**beat_bytes_lg
   // byte beats; anything up to one beat still takes a single beat.
   function automatic logic [8:0] bp_mem_num_beats(input logic [2:0] size,
                                                   input logic [2:0] beat_bytes_lg);
      logic [8:0] beats;
      if (size <= beat_bytes_lg) begin
         beats = 9'd1;
      end else begin
         beats = 9'd1 << (size - beat_bytes_lg);
      end
      return beats;
   endfunction

endpackage

// File: rtl/bp_lite_to_burst_if.sv
// bp_lite_if / bp_burst_if
//   bp_lite_if  : single-cycle Lite message {header, data} with ready-valid-and.
//                 master drives mem/mem_v, slave drives mem_ready.
//   bp_burst_if : Burst header channel plus serialized data channel, each
//                 with its own ready-valid-and handshake.
//                 master drives header/header_v/data/data_v, slave drives readies.
interface bp_lite_if #(parameter int data_width_p = 512);
   import bp_lite_to_burst_pkg::*;

   logic [mem_header_width_gp+data_width_p-1:0] mem;
   logic                                        mem_v;
   logic                                        mem_ready;

   modport master (output mem, output mem_v, input mem_ready);
   modport slave  (input mem, input mem_v, output mem_ready);
endinterface

interface bp_burst_if #(parameter int data_width_p = 64);
   import bp_lite_to_burst_pkg::*;

   bp_mem_msg_header_s      header;
   logic                    header_v;
   logic                    header_ready;
   logic [data_width_p-1:0] data;
   logic                    data_v;
   logic                    data_ready;

   modport master (output header, output header_v, input header_ready,
                   output data, output data_v, input data_ready);
   modport slave  (input header, input header_v, output header_ready,
                   input data, input data_v, output data_ready);
endinterface

// File: rtl/bp_lite_to_burst_chk.sv
// bp_lite_to_burst_chk
//   Protocol checks for the Lite-to-Burst converter.
//   clk_i, reset_n_i : clock, async active-low reset
//   accept_i         : a Lite message is accepted this cycle
//   size_i           : size code of the incoming message
module bp_lite_to_burst_chk
   import bp_lite_to_burst_pkg::*;
#(
   parameter int in_data_width_p = 512
) (
   input logic             clk_i,
   input logic             reset_n_i,
   input logic             accept_i,
   input bp_mem_msg_size_e size_i
);
   localparam int in_bytes_lg_lp = $clog2(in_data_width_p / 8);

   // A transfer wider than the Lite data bus has no data to serialise.
   size_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      accept_i |-> (int'(size_i) <= in_bytes_lg_lp));

endmodule

// File: rtl/bp_lite_to_burst_piso.sv
// bp_lite_to_burst_piso
//   Holds one wide data word and emits it as a run of narrow beats.
//   clk_i, reset_n_i : clock, async active-low reset
//   load_i           : capture data_i / num_beats_i / start_idx_i
//   num_beats_i      : beats to emit for this load
//   start_idx_i      : first word index; later beats wrap within num_beats
//   data_o, v_o      : current beat and its valid
//   ready_i          : downstream ready (ready-valid-and)
//   last_o           : the final beat is handshaking this cycle
module bp_lite_to_burst_piso #(
   parameter int in_data_width_p  = 512,
   parameter int out_data_width_p = 64,
   localparam int burst_words_lp  = in_data_width_p / out_data_width_p,
   localparam int cnt_width_lp    = (burst_words_lp > 1) ? $clog2(burst_words_lp) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        load_i,
   input  logic [in_data_width_p-1:0]  data_i,
   input  logic [cnt_width_lp:0]       num_beats_i,
   input  logic [cnt_width_lp-1:0]     start_idx_i,
   output logic [out_data_width_p-1:0] data_o,
   output logic                        v_o,
   input  logic                        ready_i,
   output logic                        last_o
);
   localparam logic [cnt_width_lp:0]   beat_one_lp = (cnt_width_lp+1)'(1'b1);
   localparam logic [cnt_width_lp-1:0] idx_one_lp  = cnt_width_lp'(1'b1);

   logic [burst_words_lp-1:0][out_data_width_p-1:0] data_q, data_d;
   logic [cnt_width_lp:0]   beats_left_q, beats_left_d;
   logic [cnt_width_lp-1:0] beat_idx_q, beat_idx_d;
   logic [cnt_width_lp-1:0] wrap_mask_q, wrap_mask_d;
   logic                    send_s;

   assign v_o    = (beats_left_q != {(cnt_width_lp+1){1'b0}});
   assign send_s = v_o & ready_i;
   assign last_o = send_s & (beats_left_q == beat_one_lp);
   assign data_o = data_q[beat_idx_q];

   // Next-state for the beat buffer: load a new word or advance one beat.
   always_comb begin
      data_d       = data_q;
      beats_left_d = beats_left_q;
      beat_idx_d   = beat_idx_q;
      wrap_mask_d  = wrap_mask_q;
      if (load_i) begin
         data_d       = data_i;
         beats_left_d = num_beats_i;
         beat_idx_d   = start_idx_i;
         // num_beats is a power of two, so num_beats-1 is the wrap mask.
         wrap_mask_d  = num_beats_i[cnt_width_lp-1:0] - idx_one_lp;
      end else if (send_s) begin
         beats_left_d = beats_left_q - beat_one_lp;
         beat_idx_d   = (beat_idx_q + idx_one_lp) & wrap_mask_q;
      end else begin
         beats_left_d = beats_left_q;
         beat_idx_d   = beat_idx_q;
      end
   end

   // Beat buffer state; reset discards any partially sent word.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_q       <= '0;
         beats_left_q <= {(cnt_width_lp+1){1'b0}};
         beat_idx_q   <= {cnt_width_lp{1'b0}};
         wrap_mask_q  <= {cnt_width_lp{1'b0}};
      end else begin
         data_q       <= data_d;
         beats_left_q <= beats_left_d;
         beat_idx_q   <= beat_idx_d;
         wrap_mask_q  <= wrap_mask_d;
      end
   end

endmodule

// File: rtl/bp_lite_to_burst.sv
// bp_lite_to_burst
//   Converts one Lite memory message (header + full-width data) into Burst
//   form: a header transaction plus N serialized data beats. One message is
//   buffered; header and data channels drain independently, and the next
//   message is taken only after both have fully handshaken.
//   Ports:
//     clk_i     : clock, rising edge
//     reset_n_i : asynchronous active-low reset
//     lite_if   : Lite input (mem, mem_v, mem_ready)
//     burst_if  : Burst output (header/header_v/header_ready, data/data_v/data_ready)
//   Build option:
//     BP_LITE_TO_BURST_CRITICAL_WORD_EN - start the beat sequence at the
//     addressed (critical) word and wrap within the size-aligned block;
//     otherwise beats always start at word 0.
module bp_lite_to_burst
   import bp_lite_to_burst_pkg::*;
#(
   parameter int          in_data_width_p  = 512,
   parameter int          out_data_width_p = 64,
   parameter logic [15:0] payload_mask_p   = 16'h0000
) (
   input logic        clk_i,
   input logic        reset_n_i,
   bp_lite_if.slave   lite_if,
   bp_burst_if.master burst_if
);
   localparam int burst_words_lp    = in_data_width_p / out_data_width_p;
   localparam int out_data_bytes_lp = out_data_width_p / 8;
   localparam int out_bytes_lg_lp   = $clog2(out_data_bytes_lp);
   localparam int cnt_width_lp      = (burst_words_lp > 1) ? $clog2(burst_words_lp) : 1;

   bp_mem_msg_header_s          in_header_s;
   logic [in_data_width_p-1:0]  in_data_s;
   bp_mem_msg_header_s          header_q, header_d;
   logic                        header_pending_q, header_pending_d;
   logic                        ready_q, ready_d;
   logic                        accept_s, has_data_s;
   logic                        data_v_s, data_last_s;
   logic [cnt_width_lp:0]       num_beats_s;
   logic [cnt_width_lp-1:0]     start_idx_s;

   assign {in_header_s, in_data_s} = lite_if.mem;

   assign accept_s    = lite_if.mem_v & ready_q;
   assign has_data_s  = payload_mask_p[in_header_s.msg_type];
   assign num_beats_s = (cnt_width_lp+1)'(bp_mem_num_beats(in_header_s.size, 3'(out_bytes_lg_lp)));

`ifdef BP_LITE_TO_BURST_CRITICAL_WORD_EN
   // Beat offset of addr inside the size-aligned block; 0 for single-beat sizes.
   assign start_idx_s = in_header_s.addr[out_bytes_lg_lp +: cnt_width_lp]
                      & (num_beats_s[cnt_width_lp-1:0] - cnt_width_lp'(1'b1));
`else
   assign start_idx_s = {cnt_width_lp{1'b0}};
`endif

   // Next-state for the header slot and the registered Lite ready.
   always_comb begin
      header_d         = header_q;
      header_pending_d = header_pending_q;
      if (accept_s) begin
         header_d         = in_header_s;
         header_pending_d = 1'b1;
      end else if (header_pending_q & burst_if.header_ready) begin
         header_pending_d = 1'b0;
      end else begin
         header_pending_d = header_pending_q;
      end
      // Ready returns the cycle after the later of header and final beat.
      ready_d = ~accept_s & ~header_pending_d & (~data_v_s | data_last_s);
   end

   // Header slot and ready flag; ready stays low while reset is asserted.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         header_q         <= '0;
         header_pending_q <= 1'b0;
         ready_q          <= 1'b0;
      end else begin
         header_q         <= header_d;
         header_pending_q <= header_pending_d;
         ready_q          <= ready_d;
      end
   end

   assign lite_if.mem_ready = ready_q;
   assign burst_if.header   = header_q;
   assign burst_if.header_v = header_pending_q;
   assign burst_if.data_v   = data_v_s;

   bp_lite_to_burst_piso #(
      .in_data_width_p (in_data_width_p),
      .out_data_width_p(out_data_width_p)
   ) data_piso (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (accept_s & has_data_s),
      .data_i     (in_data_s),
      .num_beats_i(num_beats_s),
      .start_idx_i(start_idx_s),
      .data_o     (burst_if.data),
      .v_o        (data_v_s),
      .ready_i    (burst_if.data_ready),
      .last_o     (data_last_s)
   );

   bp_lite_to_burst_chk #(
      .in_data_width_p(in_data_width_p)
   ) checker_inst (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .accept_i (accept_s),
      .size_i   (in_header_s.size)
   );

endmodule

// File: doc/bp_lite_to_burst.md
Name: bp_lite_to_burst

Overview:
- Converts a single-cycle BP Lite memory message (header plus full-width data) into BP Burst form: one header transaction plus N serialized data beats.
- Sits directly upstream of the burst-to-lite converter. It is also the converter for any Lite master driving a Burst client: CCE/LCE into the wormhole network or DRAM adapters.
- Buffers exactly one message.
- Header and data channels drain independently.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- in_data_width_p, "inv", Lite data width (wide side).
- out_data_width_p, "inv", Burst beat width (narrow side).
- payload_mask_p, 0, bitmask indexed by msg_type; a set bit means the message carries data beats.
- Derived: burst_words_lp = in_data_width_p/out_data_width_p; out_data_bytes_lp = out_data_width_p/8; cnt_width_lp = BSG_SAFE_CLOG2(burst_words_lp).

Ports:
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- mem_i  in  in_mem_msg_width_lp  Lite message {header, data}
- mem_v_i  in  1  Lite valid (ready-valid-and)
- mem_ready_o  out  1  Lite ready
- mem_header_o  out  out_mem_msg_header_width_lp  Burst header
- mem_header_v_o  out  1  header valid
- mem_header_ready_i  in  1  header ready (ready-valid-and)
- mem_data_o  out  out_data_width_p  Burst data beat
- mem_data_v_o  out  1  data valid
- mem_data_ready_i  in  1  data ready (ready-valid-and)

Behaviour:
- Interface: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i; assertion clears all state immediately, independent of the clock.
- Reset values: mem_ready_o=0 while reset is asserted, 1 from the first cycle after deassertion. mem_header_v_o=0, mem_data_v_o=0. Beat counter=0, header_pending=0, beats_left=0.
- Accept:
  - mem_ready_o = ~header_pending & (beats_left==0).
  - On mem_v_i & mem_ready_o, latch header and data into registers.
  - Set header_pending=1.
  - Set beats_left = has_data ? num_beats : 0, where has_data = payload_mask_p[msg_type].
- Beat count:
  - num_beats = max(1, (1<<size)/out_data_bytes_lp), computed in cnt_width_lp+1 bits.
  - Sizes at or below one beat produce 1 beat carrying data[out_data_width_p-1:0].
  - Sizes above in_data_width_p are illegal; flag with an assertion.
- Latency: outputs valid the cycle after accept; no combinational path from mem_i to outputs.
- Header channel:
  - mem_header_v_o = header_pending.
  - Cleared on mem_header_v_o & mem_header_ready_i.
  - The header is unmodified; size and addr pass through.
- Data channel:
  - mem_data_v_o = (beats_left!=0).
  - mem_data_o = data_r word[beat_idx].
  - On mem_data_v_o & mem_data_ready_i: beats_left-=1 and beat_idx+=1, mod num_beats.
- Channel independence:
  - Data beats may issue before, with, or after the header.
  - Header and data handshakes in the same cycle are both honoured.
- No overlap: a new message is accepted only after the header and the final beat have both handshaken. The earliest next accept is the cycle after the last handshake (1 bubble; throughput not critical).
- Non-payload messages (reads): header only; the data channel stays idle.
- Reset mid-burst: the partially sent message is discarded and no further beats are emitted.

Optional Feature:
- Macro: BP_LITE_TO_BURST_CRITICAL_WORD_EN.
- Defined: beat_idx initializes at accept to addr[BSG_SAFE_CLOG2(1<<size)-1 : log2(out_data_bytes_lp)], i.e. the critical word, and wraps modulo num_beats within the size-aligned block. When size ≤ beat, the index is 0.
- Undefined: beat_idx always starts at 0. Beats are strictly ascending.

Decomposition:
- In bp_me_pkg:
  - reuse bp_mem_msg_header_s and the bp_mem_if declare macros;
  - add a function bp_mem_num_beats(size, beat_bytes) shared with burst_to_lite.
- One natural sub-module: bsg_parallel_in_serial_out_dynamic as the data PISO. Its len is num_beats-1; it is fed only when has_data. The header uses bsg_one_fifo.
- Extend the PISO with a start-index input when the macro is enabled, or keep a local beat_idx mux.

Test Plan (in=512, out=64, 8 beats):
- Write of size 64B, data words 0..7 = 0x00..0x07, all readies high → header at cycle 1; beats 0x00..0x07 on cycles 1–8; mem_ready_o high again at cycle 9.
- Read of size 64B with the read type excluded from payload_mask_p → one header; mem_data_v_o stays 0; ready returns the cycle after the header handshake.
- Write of size 8B → exactly 1 beat equal to data[63:0].
- Write of size 64B with mem_header_ready_i held low for 10 cycles → all 8 beats drain; mem_ready_o stays 0 until the header handshakes.
- Random ready toggling on both channels, 1000 messages → scoreboard matches headers and beats in order; no beat is lost or duplicated.
- With the macro: addr offset 0x18, size 64B → beat order 3,4,5,6,7,0,1,2.
- Without the macro, same stimulus → order 0..7.
- reset_n_i pulsed low mid-burst after beat 3 → outputs drop asynchronously; no further beats; the next message is accepted normally.
